wdt_window: RTL and testbench

Parametrised windowed watchdog: the successor to the single-threshold watchdog timer. It adds configurable timeout, kick window and early-warning thresholds, a post-expiry reset pulse of programmable length, and a configuration lock. It sits beside the RISC-V core on the peripheral bus. Firmware kicks it, `o_warn` feeds the interrupt controller, and `o_reset` drives the system reset generator.

---
 rtl/wdt_window_if.sv | 30 +++
 rtl/wdt_window.sv | 140 ++++++++++++++
 tb/tb_wdt_window.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wdt_window_if.sv
// Control and status bundle for the windowed watchdog.
// The master side is firmware or bench logic; the slave side is the watchdog itself.
interface wdt_window_if #(
    parameter int unsigned WIDTH = 24
);
    logic             i_en;
    logic             i_kick;
    logic             i_clr;
    logic             i_cfg_we;
    logic [WIDTH-1:0] i_cfg_timeout;
    logic [WIDTH-1:0] i_cfg_window;
    logic [WIDTH-1:0] i_cfg_warn;
    logic             i_lock;
    logic [WIDTH-1:0] o_count;
    logic             o_warn;
    logic             o_timeout;
    logic             o_early;
    logic             o_reset;
    logic             o_locked;

    modport master (
        output i_en, i_kick, i_clr, i_cfg_we, i_cfg_timeout, i_cfg_window, i_cfg_warn, i_lock,
        input  o_count, o_warn, o_timeout, o_early, o_reset, o_locked
    );

    modport slave (
        input  i_en, i_kick, i_clr, i_cfg_we, i_cfg_timeout, i_cfg_window, i_cfg_warn, i_lock,
        output o_count, o_warn, o_timeout, o_early, o_reset, o_locked
    );
endinterface

// File: rtl/wdt_window.sv
// Windowed watchdog with early-warning threshold, programmable reset pulse and config lock.
// All outputs come straight from registers.
module wdt_window #(
    parameter int unsigned      WIDTH       = 24,
    parameter logic [WIDTH-1:0] DEF_TIMEOUT = WIDTH'(250000),
    parameter logic [WIDTH-1:0] DEF_WINDOW  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] DEF_WARN    = '0,
    parameter int unsigned      RST_CYCLES  = 16
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    wdt_window_if.slave io_wdt
);
    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRun, StExpire, StHalt} state_e;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_tmo, r_win, r_wrn;
    logic             r_warn, w_warn_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_early, w_early_nxt;
    logic             r_reset, w_reset_nxt;
    logic             r_locked;
    logic [RCW-1:0]   r_rst_cnt, w_rst_cnt_nxt;
    logic             w_en;

    // Once locked the block can no longer be disabled.
    assign w_en = io_wdt.i_en | r_locked;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state   <= StIdle;
            r_count   <= DEF_TIMEOUT;
            r_tmo     <= DEF_TIMEOUT;
            r_win     <= DEF_WINDOW;
            r_wrn     <= DEF_WARN;
            r_warn    <= 1'b0;
            r_timeout <= 1'b0;
            r_early   <= 1'b0;
            r_reset   <= 1'b0;
            r_locked  <= 1'b0;
            r_rst_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_warn    <= w_warn_nxt;
            r_timeout <= w_timeout_nxt;
            r_early   <= w_early_nxt;
            r_reset   <= w_reset_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_locked  <= r_locked | io_wdt.i_lock;
            if (io_wdt.i_cfg_we && !r_locked) begin
                r_tmo <= io_wdt.i_cfg_timeout;
                r_win <= io_wdt.i_cfg_window;
                r_wrn <= io_wdt.i_cfg_warn;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_timeout_nxt = r_timeout;
        w_early_nxt   = r_early;
        w_reset_nxt   = 1'b0;
        w_rst_cnt_nxt = r_rst_cnt;

        case (r_state)
            StIdle: begin
                w_count_nxt   = r_tmo;
                w_timeout_nxt = 1'b0;
                w_early_nxt   = 1'b0;
                w_rst_cnt_nxt = '0;
                if (w_en) w_state_nxt = StRun;
            end
            StRun: begin
                if (!w_en) begin
                    w_state_nxt   = StIdle;
                    w_count_nxt   = r_tmo;
                    w_timeout_nxt = 1'b0;
                    w_early_nxt   = 1'b0;
                end else if (io_wdt.i_kick) begin
                    if (r_count <= r_win) begin
                        w_count_nxt = r_tmo;
                    end else begin
                        w_early_nxt   = 1'b1;
                        w_state_nxt   = StExpire;
                        w_reset_nxt   = 1'b1;
                        w_rst_cnt_nxt = RCW'(1);
                    end
                end else if (r_count == '0) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = StExpire;
                    w_reset_nxt   = 1'b1;
                    w_rst_cnt_nxt = RCW'(1);
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
            StExpire: begin
                // r_rst_cnt numbers the pulse cycle currently being driven.
                if (r_rst_cnt == RCW'(RST_CYCLES)) begin
                    w_state_nxt   = StHalt;
                    w_rst_cnt_nxt = '0;
                end else begin
                    w_reset_nxt   = 1'b1;
                    w_rst_cnt_nxt = r_rst_cnt + RCW'(1);
                end
            end
            StHalt: begin
                if (!w_en) begin
                    w_state_nxt   = StIdle;
                    w_count_nxt   = r_tmo;
                    w_timeout_nxt = 1'b0;
                    w_early_nxt   = 1'b0;
                end else if (io_wdt.i_clr) begin
                    w_state_nxt   = StRun;
                    w_count_nxt   = r_tmo;
                    w_timeout_nxt = 1'b0;
                    w_early_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_count_nxt = r_tmo;
            end
        endcase

        w_warn_nxt = (w_state_nxt == StRun) && (r_wrn != '0) && (w_count_nxt <= r_wrn);
    end

    assign io_wdt.o_count   = r_count;
    assign io_wdt.o_warn    = r_warn;
    assign io_wdt.o_timeout = r_timeout;
    assign io_wdt.o_early   = r_early;
    assign io_wdt.o_reset   = r_reset;
    assign io_wdt.o_locked  = r_locked;
endmodule

// File: tb/tb_wdt_window.sv
// Directed bench for wdt_window: expiry, kicks, warning, lock and async reset.
module tb_wdt_window;
    localparam int unsigned WIDTH = 24;
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;
    logic seen_warn;

    wdt_window_if #(.WIDTH(WIDTH)) u_if ();

    wdt_window #(
        .WIDTH      (WIDTH),
        .DEF_TIMEOUT(WIDTH'(250000)),
        .DEF_WINDOW (ALL_ONES),
        .DEF_WARN   ('0),
        .RST_CYCLES (16)
    ) u_dut (
        .i_clk   (clk),
        .i_resetn(resetn),
        .io_wdt  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [WIDTH-1:0] tmo, input logic [WIDTH-1:0] win,
                       input logic [WIDTH-1:0] wrn);
        u_if.i_cfg_we      = 1'b1;
        u_if.i_cfg_timeout = tmo;
        u_if.i_cfg_window  = win;
        u_if.i_cfg_warn    = wrn;
        tick(1);
        u_if.i_cfg_we = 1'b0;
    endtask

    task automatic kick();
        u_if.i_kick = 1'b1;
        tick(1);
        u_if.i_kick = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b1;
        u_if.i_en = 1'b0;
        u_if.i_kick = 1'b0;
        u_if.i_clr = 1'b0;
        u_if.i_cfg_we = 1'b0;
        u_if.i_cfg_timeout = '0;
        u_if.i_cfg_window = '0;
        u_if.i_cfg_warn = '0;
        u_if.i_lock = 1'b0;
        #1 resetn = 1'b0;
        #2;
        check("rst_count",   32'(u_if.o_count), 32'd250000);
        check("rst_warn",    32'(u_if.o_warn), 32'd0);
        check("rst_timeout", 32'(u_if.o_timeout), 32'd0);
        check("rst_early",   32'(u_if.o_early), 32'd0);
        check("rst_reset",   32'(u_if.o_reset), 32'd0);
        check("rst_locked",  32'(u_if.o_locked), 32'd0);
        tick(1);
        resetn = 1'b1;

        // Basic expiry with timeout 10.
        cfg(24'd10, ALL_ONES, 24'd0);
        check("cfg_keeps_count", 32'(u_if.o_count), 32'd250000);
        tick(1);
        check("idle_count", 32'(u_if.o_count), 32'd10);
        u_if.i_en = 1'b1;
        tick(1);
        check("run_load", 32'(u_if.o_count), 32'd10);
        tick(10);
        check("run_zero", 32'(u_if.o_count), 32'd0);
        check("zero_no_tmo", 32'(u_if.o_timeout), 32'd0);
        tick(1);
        check("exp_timeout", 32'(u_if.o_timeout), 32'd1);
        check("exp_reset_rise", 32'(u_if.o_reset), 32'd1);
        tick(15);
        check("exp_reset_16th", 32'(u_if.o_reset), 32'd1);
        tick(1);
        check("exp_reset_fall", 32'(u_if.o_reset), 32'd0);
        tick(3);
        check("halt_count", 32'(u_if.o_count), 32'd0);
        check("halt_timeout", 32'(u_if.o_timeout), 32'd1);
        u_if.i_clr = 1'b1;
        tick(1);
        u_if.i_clr = 1'b0;
        check("clr_count", 32'(u_if.o_count), 32'd10);
        check("clr_timeout", 32'(u_if.o_timeout), 32'd0);
        tick(1);
        check("clr_dec", 32'(u_if.o_count), 32'd9);

        // Legal kicks at count 15 and at count 0.
        u_if.i_en = 1'b0;
        tick(1);
        cfg(24'd100, 24'd20, 24'd0);
        tick(1);
        u_if.i_en = 1'b1;
        tick(1);
        check("k_load", 32'(u_if.o_count), 32'd100);
        tick(85);
        check("k_at15", 32'(u_if.o_count), 32'd15);
        kick();
        check("k15_reload", 32'(u_if.o_count), 32'd100);
        check("k15_early", 32'(u_if.o_early), 32'd0);
        tick(100);
        check("k_at0", 32'(u_if.o_count), 32'd0);
        kick();
        check("k0_reload", 32'(u_if.o_count), 32'd100);
        check("k0_timeout", 32'(u_if.o_timeout), 32'd0);
        check("k0_reset", 32'(u_if.o_reset), 32'd0);

        // Early kick at count 50.
        tick(50);
        check("e_at50", 32'(u_if.o_count), 32'd50);
        kick();
        check("e_early", 32'(u_if.o_early), 32'd1);
        check("e_timeout", 32'(u_if.o_timeout), 32'd0);
        check("e_reset", 32'(u_if.o_reset), 32'd1);
        tick(15);
        check("e_reset_16th", 32'(u_if.o_reset), 32'd1);
        tick(1);
        check("e_reset_fall", 32'(u_if.o_reset), 32'd0);
        check("e_early_sticky", 32'(u_if.o_early), 32'd1);
        u_if.i_en = 1'b0;
        tick(1);
        check("e_idle_clear", 32'(u_if.o_early), 32'd0);

        // Warning threshold 30.
        cfg(24'd100, ALL_ONES, 24'd30);
        tick(1);
        u_if.i_en = 1'b1;
        tick(1);
        check("w_load_warn", 32'(u_if.o_warn), 32'd0);
        tick(69);
        check("w_31_count", 32'(u_if.o_count), 32'd31);
        check("w_31_warn", 32'(u_if.o_warn), 32'd0);
        tick(1);
        check("w_30_warn", 32'(u_if.o_warn), 32'd1);
        tick(1);
        check("w_29_warn", 32'(u_if.o_warn), 32'd1);
        kick();
        check("w_kick_count", 32'(u_if.o_count), 32'd100);
        check("w_kick_warn", 32'(u_if.o_warn), 32'd0);

        // Warning threshold 0 never warns.
        u_if.i_en = 1'b0;
        tick(1);
        cfg(24'd100, ALL_ONES, 24'd0);
        u_if.i_en = 1'b1;
        tick(1);
        seen_warn = u_if.o_warn;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            seen_warn = seen_warn | u_if.o_warn;
        end
        check("w0_at0", 32'(u_if.o_count), 32'd0);
        check("w0_never", 32'(seen_warn), 32'd0);
        u_if.i_en = 1'b0;
        tick(1);

        // Lock: later config write and disable are ignored.
        cfg(24'd40, ALL_ONES, 24'd0);
        tick(1);
        u_if.i_lock = 1'b1;
        u_if.i_en   = 1'b1;
        tick(1);
        u_if.i_lock = 1'b0;
        check("l_locked", 32'(u_if.o_locked), 32'd1);
        check("l_load", 32'(u_if.o_count), 32'd40);
        u_if.i_en = 1'b0;
        cfg(24'd5, ALL_ONES, 24'd0);
        check("l_still_run", 32'(u_if.o_count), 32'd39);
        tick(39);
        check("l_at0", 32'(u_if.o_count), 32'd0);
        tick(1);
        check("l_timeout", 32'(u_if.o_timeout), 32'd1);
        tick(16);
        u_if.i_clr = 1'b1;
        tick(1);
        u_if.i_clr = 1'b0;
        check("l_tmo_kept", 32'(u_if.o_count), 32'd40);
        check("l_locked_kept", 32'(u_if.o_locked), 32'd1);

        // Async reset on the third cycle of the pulse.
        tick(41);
        check("a_reset_on", 32'(u_if.o_reset), 32'd1);
        tick(2);
        #2 resetn = 1'b0;
        #1;
        check("a_reset", 32'(u_if.o_reset), 32'd0);
        check("a_count", 32'(u_if.o_count), 32'd250000);
        check("a_timeout", 32'(u_if.o_timeout), 32'd0);
        check("a_locked", 32'(u_if.o_locked), 32'd0);
        check("a_warn", 32'(u_if.o_warn), 32'd0);
        check("a_early", 32'(u_if.o_early), 32'd0);
        tick(1);
        resetn = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
